// File: rtl/manipulation_pkg.sv
// Shared types, constants and the saturation helper for the pixel-manipulation stage.
package manipulation_pkg;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SCALE  = 2'd1,
    ADD    = 2'd2,
    GRAY   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_GBR  = 2'd1,
    ROT_BRG  = 2'd2,
    ROT_BGR  = 2'd3
  } rot_e;

  localparam logic [7:0] GRAY_R_COEF = 8'd77;
  localparam logic [7:0] GRAY_G_COEF = 8'd150;
  localparam logic [7:0] GRAY_B_COEF = 8'd29;
  localparam logic [7:0] CH_MAX      = 8'd255;

  function automatic logic [7:0] sat_u8(input int v);
    logic [7:0] res;
    if (v < 32'sd0) begin
      res = 8'd0;
    end else if (v > 32'sd255) begin
      res = CH_MAX;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/manipulation_sat.sv
// Clamps one signed 32-bit operand symbol into the unsigned 8-bit channel range.
module manipulation_sat
  import manipulation_pkg::*;
(
  input  logic signed [31:0] sym_i,
  output logic        [7:0]  sat_o
);

  assign sat_o = sat_u8(sym_i);

endmodule

// File: rtl/manipulation_unit.sv
// Two-stage pixel manipulation: saturate operands, then colour op, channel rotate
// and optional invert into registered RGB outputs.
module manipulation_unit
  import manipulation_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic        [7:0]  data_in,
  input  logic signed [31:0] symbol_0,
  input  logic signed [31:0] symbol_1,
  input  logic signed [31:0] symbol_2,
  input  logic signed [31:0] symbol_3,
  output logic        [7:0]  r_out,
  output logic        [7:0]  g_out,
  output logic        [7:0]  b_out
);

  logic [7:0]  s0_d, s1_d, s2_d, s3_d;
  logic [7:0]  s0_q, s1_q, s2_q, s3_q;
  logic [4:0]  ctrl_d, ctrl_q;
  logic [7:0]  r_d, g_d, b_d;
  logic [7:0]  r_q, g_q, b_q;

  logic [15:0] prod_r, prod_g, prod_b, gray_sum;
  logic [8:0]  sum_r, sum_g, sum_b;
  logic [7:0]  mix_r, mix_g, mix_b;
  logic [7:0]  rot_r, rot_g, rot_b;

  // Reserved control bits are intentionally not carried into the pipeline.
  logic unused_rsvd;
  assign unused_rsvd = &{1'b0, data_in[7:5]};

  manipulation_sat u_sat0 (.sym_i(symbol_0), .sat_o(s0_d));
  manipulation_sat u_sat1 (.sym_i(symbol_1), .sat_o(s1_d));
  manipulation_sat u_sat2 (.sym_i(symbol_2), .sat_o(s2_d));
  manipulation_sat u_sat3 (.sym_i(symbol_3), .sat_o(s3_d));

  assign ctrl_d = data_in[4:0];

  always_comb begin
    prod_r   = {8'd0, s0_q} * {8'd0, s3_q};
    prod_g   = {8'd0, s1_q} * {8'd0, s3_q};
    prod_b   = {8'd0, s2_q} * {8'd0, s3_q};
    sum_r    = {1'b0, s0_q} + {1'b0, s3_q};
    sum_g    = {1'b0, s1_q} + {1'b0, s3_q};
    sum_b    = {1'b0, s2_q} + {1'b0, s3_q};
    // Coefficients sum to 256, so the high byte never overflows.
    gray_sum = ({8'd0, GRAY_R_COEF} * {8'd0, s0_q})
             + ({8'd0, GRAY_G_COEF} * {8'd0, s1_q})
             + ({8'd0, GRAY_B_COEF} * {8'd0, s2_q});

    mix_r = s0_q;
    mix_g = s1_q;
    mix_b = s2_q;
    case (mode_e'(ctrl_q[1:0]))
      DIRECT: begin
        mix_r = s0_q;
        mix_g = s1_q;
        mix_b = s2_q;
      end
      SCALE: begin
        mix_r = 8'(prod_r >> 8);
        mix_g = 8'(prod_g >> 8);
        mix_b = 8'(prod_b >> 8);
      end
      ADD: begin
        mix_r = (sum_r > 9'd255) ? CH_MAX : 8'(sum_r);
        mix_g = (sum_g > 9'd255) ? CH_MAX : 8'(sum_g);
        mix_b = (sum_b > 9'd255) ? CH_MAX : 8'(sum_b);
      end
      GRAY: begin
        mix_r = 8'(gray_sum >> 8);
        mix_g = 8'(gray_sum >> 8);
        mix_b = 8'(gray_sum >> 8);
      end
      default: begin
        mix_r = s0_q;
        mix_g = s1_q;
        mix_b = s2_q;
      end
    endcase

    rot_r = mix_r;
    rot_g = mix_g;
    rot_b = mix_b;
    case (rot_e'(ctrl_q[3:2]))
      ROT_NONE: begin
        rot_r = mix_r;
        rot_g = mix_g;
        rot_b = mix_b;
      end
      ROT_GBR: begin
        rot_r = mix_g;
        rot_g = mix_b;
        rot_b = mix_r;
      end
      ROT_BRG: begin
        rot_r = mix_b;
        rot_g = mix_r;
        rot_b = mix_g;
      end
      ROT_BGR: begin
        rot_r = mix_b;
        rot_g = mix_g;
        rot_b = mix_r;
      end
      default: begin
        rot_r = mix_r;
        rot_g = mix_g;
        rot_b = mix_b;
      end
    endcase

    if (ctrl_q[4]) begin
      r_d = CH_MAX - rot_r;
      g_d = CH_MAX - rot_g;
      b_d = CH_MAX - rot_b;
    end else begin
      r_d = rot_r;
      g_d = rot_g;
      b_d = rot_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= 8'd0;
      s1_q   <= 8'd0;
      s2_q   <= 8'd0;
      s3_q   <= 8'd0;
      ctrl_q <= 5'd0;
      r_q    <= 8'd0;
      g_q    <= 8'd0;
      b_q    <= 8'd0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      ctrl_q <= ctrl_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;

endmodule

// File: tb/tb_manipulation_unit.sv
// Self-checking bench for manipulation_unit: directed test-plan vectors plus a
// randomized run against a behavioural reference model with a 2-cycle latency queue.
module tb_manipulation_unit;

  logic               clk;
  logic               reset;
  logic        [7:0]  data_in;
  logic signed [31:0] symbol_0, symbol_1, symbol_2, symbol_3;
  logic        [7:0]  r_out, g_out, b_out;

  int checks;
  int errors;
  logic [23:0] exp_out;
  logic [23:0] pend;

  manipulation_unit dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .symbol_0 (symbol_0),
    .symbol_1 (symbol_1),
    .symbol_2 (symbol_2),
    .symbol_3 (symbol_3),
    .r_out    (r_out),
    .g_out    (g_out),
    .b_out    (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: straight from the arithmetic rules, one pixel at a time.
  function automatic logic [23:0] model(input logic [7:0] d, input int a, input int b,
                                        input int c, input int e);
    int s[4];
    int ch[3];
    int o[3];
    s[0] = clamp(a); s[1] = clamp(b); s[2] = clamp(c); s[3] = clamp(e);
    for (int k = 0; k < 3; k++) begin
      case (d[1:0])
        2'd0: ch[k] = s[k];
        2'd1: ch[k] = (s[k] * s[3]) / 256;
        2'd2: ch[k] = (s[k] + s[3] > 255) ? 255 : s[k] + s[3];
        default: ch[k] = (77 * s[0] + 150 * s[1] + 29 * s[2]) / 256;
      endcase
    end
    case (d[3:2])
      2'd0: begin o[0] = ch[0]; o[1] = ch[1]; o[2] = ch[2]; end
      2'd1: begin o[0] = ch[1]; o[1] = ch[2]; o[2] = ch[0]; end
      2'd2: begin o[0] = ch[2]; o[1] = ch[0]; o[2] = ch[1]; end
      default: begin o[0] = ch[2]; o[1] = ch[1]; o[2] = ch[0]; end
    endcase
    if (d[4]) begin
      for (int k = 0; k < 3; k++) o[k] = 255 - o[k];
    end
    return {8'(o[0]), 8'(o[1]), 8'(o[2])};
  endfunction

  // One clock: drive inputs, take the edge, advance the 2-deep expected pipeline.
  task automatic step(input logic [7:0] d, input int a, input int b, input int c,
                      input int e, input logic rst);
    data_in  = d;
    symbol_0 = a;
    symbol_1 = b;
    symbol_2 = c;
    symbol_3 = e;
    reset    = rst;
    @(posedge clk);
    #1;
    exp_out = rst ? 24'd0 : pend;
    pend    = rst ? 24'd0 : model(d, a, b, c, e);
  endtask

  task automatic test_reset();
    step(8'h00, 1, 2, 3, 4, 1'b1);
    step(8'h00, 1, 2, 3, 4, 1'b1);
    checks++;
    if ({r_out, g_out, b_out} !== 24'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {r_out, g_out, b_out}, 24'd0);
    end
  endtask

  task automatic test_direct();
    step(8'h00, 10, 20, 30, 99, 1'b0);
    step(8'h00, 10, 20, 30, 99, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd10, 8'd20, 8'd30}) begin
      errors++;
      $display("FAIL direct: got %h expected %h", {r_out, g_out, b_out}, {8'd10, 8'd20, 8'd30});
    end
  endtask

  task automatic test_saturation();
    step(8'h00, -5, 300, 255, 0, 1'b0);
    step(8'h00, -5, 300, 255, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd0, 8'd255, 8'd255}) begin
      errors++;
      $display("FAIL saturation: got %h expected %h", {r_out, g_out, b_out}, {8'd0, 8'd255, 8'd255});
    end
  endtask

  task automatic test_scale_add();
    step(8'h01, 200, 100, 0, 128, 1'b0);
    step(8'h02, 200, 100, 0, 128, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd100, 8'd50, 8'd0}) begin
      errors++;
      $display("FAIL scale: got %h expected %h", {r_out, g_out, b_out}, {8'd100, 8'd50, 8'd0});
    end
    step(8'h02, 200, 100, 0, 128, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd255, 8'd228, 8'd128}) begin
      errors++;
      $display("FAIL add: got %h expected %h", {r_out, g_out, b_out}, {8'd255, 8'd228, 8'd128});
    end
  endtask

  task automatic test_gray();
    step(8'h03, 255, 255, 255, 0, 1'b0);
    step(8'h03, 100, 0, 0, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd255, 8'd255, 8'd255}) begin
      errors++;
      $display("FAIL gray_white: got %h expected %h", {r_out, g_out, b_out}, {8'd255, 8'd255, 8'd255});
    end
    step(8'h03, 100, 0, 0, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd30, 8'd30, 8'd30}) begin
      errors++;
      $display("FAIL gray_100: got %h expected %h", {r_out, g_out, b_out}, {8'd30, 8'd30, 8'd30});
    end
  endtask

  task automatic test_rotate_invert();
    step(8'h14, 10, 20, 30, 0, 1'b0);
    step(8'h14, 10, 20, 30, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd235, 8'd225, 8'd245}) begin
      errors++;
      $display("FAIL rotate_invert: got %h expected %h", {r_out, g_out, b_out}, {8'd235, 8'd225, 8'd245});
    end
    // Reserved bits set, swap R/B, no invert.
    step(8'hEC, 10, 20, 30, 0, 1'b0);
    step(8'hEC, 10, 20, 30, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd30, 8'd20, 8'd10}) begin
      errors++;
      $display("FAIL swap_reserved: got %h expected %h", {r_out, g_out, b_out}, {8'd30, 8'd20, 8'd10});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] want [3];
    want[0] = {8'd1, 8'd2, 8'd3};
    want[1] = {8'd4, 8'd5, 8'd6};
    want[2] = {8'd248, 8'd247, 8'd246};
    step(8'h00, 1, 2, 3, 0, 1'b0);
    step(8'h00, 4, 5, 6, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== want[0]) begin
      errors++;
      $display("FAIL b2b_0: got %h expected %h", {r_out, g_out, b_out}, want[0]);
    end
    step(8'h10, 7, 8, 9, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== want[1]) begin
      errors++;
      $display("FAIL b2b_1: got %h expected %h", {r_out, g_out, b_out}, want[1]);
    end
    step(8'h00, 0, 0, 0, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== want[2]) begin
      errors++;
      $display("FAIL b2b_2: got %h expected %h", {r_out, g_out, b_out}, want[2]);
    end
  endtask

  task automatic test_reset_mid();
    step(8'h00, 11, 12, 13, 0, 1'b0);
    step(8'h00, 21, 22, 23, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd11, 8'd12, 8'd13}) begin
      errors++;
      $display("FAIL mid_pre: got %h expected %h", {r_out, g_out, b_out}, {8'd11, 8'd12, 8'd13});
    end
    step(8'h00, 31, 32, 33, 0, 1'b1);
    checks++;
    if ({r_out, g_out, b_out} !== 24'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", {r_out, g_out, b_out}, 24'd0);
    end
    step(8'h00, 41, 42, 43, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== 24'd0) begin
      errors++;
      $display("FAIL mid_flushed: got %h expected %h", {r_out, g_out, b_out}, 24'd0);
    end
    step(8'h00, 51, 52, 53, 0, 1'b0);
    checks++;
    if ({r_out, g_out, b_out} !== {8'd41, 8'd42, 8'd43}) begin
      errors++;
      $display("FAIL mid_resume: got %h expected %h", {r_out, g_out, b_out}, {8'd41, 8'd42, 8'd43});
    end
  endtask

  function automatic int rand_sym();
    case ($urandom_range(3, 0))
      0: return int'($urandom);
      1: return int'($urandom_range(600, 0)) - 300;
      default: return int'($urandom_range(255, 0));
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 128; i++) begin
      step(8'($urandom), rand_sym(), rand_sym(), rand_sym(), rand_sym(),
           ($urandom_range(31, 0) == 0));
      checks++;
      if ({r_out, g_out, b_out} !== exp_out) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, {r_out, g_out, b_out}, exp_out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_out  = 24'd0;
    pend     = 24'd0;
    reset    = 1'b1;
    data_in  = 8'h00;
    symbol_0 = 0;
    symbol_1 = 0;
    symbol_2 = 0;
    symbol_3 = 0;
    test_reset();
    test_direct();
    test_saturation();
    test_scale_add();
    test_gray();
    test_rotate_invert();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/manipulation_unit.md
# manipulation_unit

Pixel-manipulation stage of the light_nn datapath. Each cycle it takes four operand symbols and one control byte and produces one registered RGB triple. The block saturates the operands and applies one of four colour operations. It then optionally rotates the channels and inverts the result. It sits between the symbol-producing front end and the RGB output/display logic.

## Interface
- No parameters. Data width is fixed at 8 bits per channel.
- `clk` input, 1 bit: sole clock, rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `data_in` input, 8 bits: control byte.
  - [1:0] mode.
  - [3:2] rotate.
  - [4] invert.
  - [7:5] reserved; ignored.
- `symbol_0` … `symbol_3` input, 32 bits signed each: operands. The front end drives integers, which may be negative or exceed 255.
- `r_out`, `g_out`, `b_out` output, 8 bits each: registered result channels.

## Operation
- Saturation: `s_k = clamp(symbol_k, 0, 255)` for k = 0..3.
  - Negative values give 0.
  - Values above 255 give 255.
- Mode, from `data_in[1:0]`, produces an intermediate triple (R, G, B):
  - 00 DIRECT: (s0, s1, s2).
  - 01 SCALE: each channel is `(s_k * s3) >> 8` for k = 0..2. The product is 16 bits; truncate, do not round.
  - 10 ADD: each channel is `min(s_k + s3, 255)`. Use a 9-bit sum, then saturate.
  - 11 GRAY: `y = (77*s0 + 150*s1 + 29*s2) >> 8`, and R = G = B = y. The coefficients sum to 256, so y ≤ 255 and needs no clamp.
- Rotate, from `data_in[3:2]`, is applied after the mode:
  - 00: (R, G, B) unchanged.
  - 01: (G, B, R).
  - 10: (B, R, G).
  - 11: (B, G, R), i.e. R and B swapped.
- Invert, from `data_in[4]`: when 1, each channel becomes `255 - channel`. It is applied last.
- Reserved bits [7:5] have no effect.
- All arithmetic is unsigned after saturation.
- No input/output handshake: the block accepts a new input set every cycle.

## Timing
- Two-stage pipeline, latency 2 cycles, throughput 1 result per cycle.
- Stage 1, edge N: register the saturated s0..s3 and `data_in[4:0]`.
- Stage 2, edge N+1: compute mode, rotate and invert, then register `r_out`, `g_out`, `b_out`.
- Inputs sampled at edge N appear on the outputs after edge N+1.
- Reset behaviour:
  - At any edge with `reset` = 1, both stages clear: all pipeline registers and all three outputs become 0.
  - When reset is asserted mid-stream, in-flight data is discarded.
- After reset:
  - The first valid result appears 2 edges after the first non-reset sampling edge.
  - Until then, the outputs stay 0.
- Back-to-back changes to the inputs produce back-to-back results with no bubbles.

## Structure
- Package `manipulation_pkg` holds:
  - mode enum: DIRECT, SCALE, ADD, GRAY;
  - rotate enum;
  - gray coefficients 77/150/29;
  - constant `CH_MAX = 8'd255`;
  - function `sat_u8(int)`.
- Sub-module `manipulation_sat`: 32-bit signed to 8-bit unsigned clamp, instantiated four times. Everything else is flat in `manipulation_unit`.

## Test plan
- DIRECT: `data_in`=0x00, symbols 10/20/30/99 → after 2 cycles, r/g/b = 10/20/30.
- Saturation: `data_in`=0x00, symbols −5/300/255/0 → 0/255/255.
- SCALE and ADD, with s0..s2 = 200/100/0 and s3 = 128:
  - `data_in`=0x01 → 100/50/0.
  - `data_in`=0x02 → 255/228/128.
- GRAY: `data_in`=0x03 with symbols 255/255/255/0 → 255/255/255. With symbols 100/0/0/0 → 30/30/30.
- Rotate + invert: `data_in`=0x14, symbols 10/20/30/0 → 235/225/245.
- Reset and pipelining:
  - Stream 3 distinct vectors on consecutive cycles; each appears exactly 2 cycles later, in order.
  - Assert `reset` for 1 cycle mid-stream; the outputs are 0 on the next edge, and in-flight results never appear.
  - Random regression: 128 random vectors checked against a reference model.
